// File: rtl/serial_complementer.sv
// -----------------------------------------------------------------------------
// serial_complementer
//   Accepts a WIDTH-bit word over a valid/ready handshake and walks it LSB
//   first, one bit per clock, producing either the ones' complement
//   (in_mode=0) or the two's complement (in_mode=1). The result is returned
//   over a second valid/ready handshake and stays registered until the next
//   completion or reset.
//
//   Optional build macro: OVERFLOW_DETECT_EN
//     Adds a registered 'overflow' output that flags negation of the most
//     negative value (1 followed by WIDTH-1 zeros) in two's-complement mode.
// -----------------------------------------------------------------------------
module serial_complementer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef OVERFLOW_DETECT_EN
  ,
  output logic             overflow
`endif
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q,    state_d;
  logic [WIDTH-1:0]   sreg_q,     sreg_d;
  logic [WIDTH-1:0]   rreg_q,     rreg_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               mode_q,     mode_d;
  logic               seen_one_q, seen_one_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
`ifdef OVERFLOW_DETECT_EN
  logic               overflow_q, overflow_d;
`endif

  // Current serial bit and its complemented value. In two's-complement mode
  // bits are copied up to and including the first 1, then inverted above it.
  logic             cur_bit;
  logic             out_bit;
  logic [WIDTH-1:0] rreg_shifted;

  assign cur_bit      = sreg_q[0];
  assign out_bit      = (mode_q && !seen_one_q) ? cur_bit : ~cur_bit;
  assign rreg_shifted = {out_bit, rreg_q[WIDTH-1:1]};

  // Handshake and status outputs are pure decodes of the registered state.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
`ifdef OVERFLOW_DETECT_EN
  assign overflow  = overflow_q;
`endif

  // Next-state and datapath update logic.
  always_comb begin
    // NOTE: every _d is first given its hold value so no path through the
    // case statement leaves a signal unassigned, which would infer a latch.
    state_d    = state_q;
    sreg_d     = sreg_q;
    rreg_d     = rreg_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    seen_one_d = seen_one_q;
    out_data_d = out_data_q;
`ifdef OVERFLOW_DETECT_EN
    overflow_d = overflow_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d     = in_data;
          mode_d     = in_mode;
          cnt_d      = '0;
          seen_one_d = 1'b0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        seen_one_d = seen_one_q | cur_bit;
        sreg_d     = {1'b0, sreg_q[WIDTH-1:1]};
        rreg_d     = rreg_shifted;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          out_data_d = rreg_shifted;
`ifdef OVERFLOW_DETECT_EN
          // Last bit is the MSB: overflow iff it is 1 and no lower bit was.
          overflow_d = mode_q & ~seen_one_q & cur_bit;
`endif
          state_d    = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous, highest-priority reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      rreg_q     <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      seen_one_q <= 1'b0;
      out_data_q <= '0;
`ifdef OVERFLOW_DETECT_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      rreg_q     <= rreg_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      seen_one_q <= seen_one_d;
      out_data_q <= out_data_d;
`ifdef OVERFLOW_DETECT_EN
      overflow_q <= overflow_d;
`endif
    end
  end

endmodule
